// File: rtl/uart_queue_ctrl.sv
// Buffered UART controller: TX/RX FIFOs between the j1 IO decode and the byte UART.
// Optional interrupt output enabled by defining UART_QUEUE_IRQ_EN.
module uart_queue_ctrl #(
  parameter int TX_AW = 4,
  parameter int RX_AW = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_push,
  input  logic [7:0] tx_data,
  input  logic       rx_pop,
  output logic [7:0] rx_data,
  input  logic       flag_clr,
  output logic [7:0] status,
  output logic       uart_wr,
  output logic [7:0] uart_w,
  input  logic       uart_busy,
  output logic       uart_rd,
  input  logic       uart_valid,
  input  logic [7:0] uart_data
`ifdef UART_QUEUE_IRQ_EN
  ,
  output logic       irq
`endif
);

  localparam int TX_D = 1 << TX_AW;
  localparam int RX_D = 1 << RX_AW;
  localparam logic [TX_AW:0] TX_DEPTH = (TX_AW + 1)'(TX_D);
  localparam logic [RX_AW:0] RX_DEPTH = (RX_AW + 1)'(RX_D);

  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_HOLD} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_HOLD} rx_state_t;

  tx_state_t tx_state, tx_state_nxt;
  rx_state_t rx_state, rx_state_nxt;

  logic [7:0]       tx_mem [TX_D];
  logic [7:0]       rx_mem [RX_D];
  logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [TX_AW:0]   tx_cnt, tx_cnt_nxt;
  logic [RX_AW:0]   rx_cnt, rx_cnt_nxt;
  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic             tx_push_ok, tx_pop_ok, rx_push, rx_push_ok, rx_pop_ok;
  logic             tx_ovf, rx_ovf, tx_ovf_nxt, rx_ovf_nxt;
  logic [7:0]       uart_w_q;

  assign tx_full    = (tx_cnt == TX_DEPTH);
  assign tx_empty   = (tx_cnt == '0);
  assign rx_full    = (rx_cnt == RX_DEPTH);
  assign rx_empty   = (rx_cnt == '0);
  assign tx_push_ok = tx_push && !tx_full;
  assign rx_push_ok = rx_push && !rx_full;
  assign rx_pop_ok  = rx_pop && !rx_empty;
  assign rx_data    = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];
  assign uart_w     = uart_w_q;

  always_comb begin
    tx_state_nxt = tx_state;
    uart_wr      = 1'b0;
    tx_pop_ok    = 1'b0;
    case (tx_state)
      TX_IDLE: if (!tx_empty && !uart_busy) tx_state_nxt = TX_SEND;
      TX_SEND: begin
        uart_wr      = 1'b1;
        tx_pop_ok    = 1'b1;
        tx_state_nxt = TX_HOLD;
      end
      TX_HOLD: tx_state_nxt = TX_IDLE;
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  // RX only acks when space is guaranteed, so the UART keeps the byte while full
  always_comb begin
    rx_state_nxt = rx_state;
    uart_rd      = 1'b0;
    rx_push      = 1'b0;
    case (rx_state)
      RX_IDLE: if (uart_valid && !rx_full) rx_state_nxt = RX_ACK;
      RX_ACK: begin
        uart_rd      = 1'b1;
        rx_push      = 1'b1;
        rx_state_nxt = RX_HOLD;
      end
      RX_HOLD: rx_state_nxt = RX_IDLE;
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    tx_cnt_nxt = tx_cnt;
    if (tx_push_ok && !tx_pop_ok)      tx_cnt_nxt = tx_cnt + (TX_AW + 1)'(1);
    else if (!tx_push_ok && tx_pop_ok) tx_cnt_nxt = tx_cnt - (TX_AW + 1)'(1);
    rx_cnt_nxt = rx_cnt;
    if (rx_push_ok && !rx_pop_ok)      rx_cnt_nxt = rx_cnt + (RX_AW + 1)'(1);
    else if (!rx_push_ok && rx_pop_ok) rx_cnt_nxt = rx_cnt - (RX_AW + 1)'(1);
    // an overflow in the same cycle as flag_clr keeps the flag set
    tx_ovf_nxt = (tx_push && tx_full) || (tx_ovf && !flag_clr);
    rx_ovf_nxt = (rx_push && rx_full) || (rx_ovf && !flag_clr);
  end

  always_ff @(posedge clk) begin
    if (tx_push_ok) tx_mem[tx_wr_ptr] <= tx_data;
    if (rx_push_ok) rx_mem[rx_wr_ptr] <= uart_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state  <= TX_IDLE;
      rx_state  <= RX_IDLE;
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      tx_cnt    <= '0;
      rx_cnt    <= '0;
      tx_ovf    <= 1'b0;
      rx_ovf    <= 1'b0;
      uart_w_q  <= 8'h00;
      status    <= 8'h01;
    end else begin
      tx_state <= tx_state_nxt;
      rx_state <= rx_state_nxt;
      if (tx_push_ok) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
      if (tx_pop_ok)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
      if (rx_push_ok) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
      if (rx_pop_ok)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
      tx_cnt <= tx_cnt_nxt;
      rx_cnt <= rx_cnt_nxt;
      tx_ovf <= tx_ovf_nxt;
      rx_ovf <= rx_ovf_nxt;
      // uart_w is loaded on entry to SEND and then held until the next launch
      if (tx_state == TX_IDLE && tx_state_nxt == TX_SEND) uart_w_q <= tx_mem[tx_rd_ptr];
      status <= {2'b00, rx_ovf_nxt, tx_ovf_nxt,
                 rx_cnt_nxt == RX_DEPTH, rx_cnt_nxt != '0,
                 tx_cnt_nxt == TX_DEPTH, tx_cnt_nxt == '0};
    end
  end

`ifdef UART_QUEUE_IRQ_EN
  logic tx_done_arm;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_done_arm <= 1'b0;
      irq         <= 1'b0;
    end else begin
      if (tx_state == TX_SEND) tx_done_arm <= 1'b1;
      else if (flag_clr)       tx_done_arm <= 1'b0;
      irq <= !rx_empty || (tx_empty && tx_state == TX_IDLE && tx_done_arm);
    end
  end
`endif

endmodule

// File: tb/tb_uart_queue_ctrl.sv
// Directed self-checking bench for uart_queue_ctrl (default build).
module tb_uart_queue_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_push = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       rx_pop = 1'b0;
  logic [7:0] rx_data;
  logic       flag_clr = 1'b0;
  logic [7:0] status;
  logic       uart_wr;
  logic [7:0] uart_w;
  logic       uart_busy = 1'b0;
  logic       uart_rd;
  logic       uart_valid = 1'b0;
  logic [7:0] uart_data = 8'h00;
`ifdef UART_QUEUE_IRQ_EN
  logic       irq;
`endif

  uart_queue_ctrl #(.TX_AW(4), .RX_AW(4)) dut (
    .clk(clk), .reset(reset), .tx_push(tx_push), .tx_data(tx_data),
    .rx_pop(rx_pop), .rx_data(rx_data), .flag_clr(flag_clr), .status(status),
    .uart_wr(uart_wr), .uart_w(uart_w), .uart_busy(uart_busy),
    .uart_rd(uart_rd), .uart_valid(uart_valid), .uart_data(uart_data)
`ifdef UART_QUEUE_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rd_cnt = 0;
  logic [7:0] wr_log[$];
  int         wr_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && uart_wr) begin
      wr_log.push_back(uart_w);
      wr_cyc.push_back(cyc);
    end
    if (!reset && uart_rd) rd_cnt <= rd_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rx_byte(input logic [7:0] d, input int maxc, output bit acked);
    acked = 1'b0;
    uart_valid = 1'b1;
    uart_data = d;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (uart_rd) begin
        acked = 1'b1;
        break;
      end
    end
    if (acked) begin
      uart_valid = 1'b0;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit acked;
    bit got;
    int acks;
    int rd0;
    logic [7:0] exp_b;

    // reset and idle
    tick(3);
    chk("rst_status", status, 8'h01);
    chk("rst_uart_wr", uart_wr, 1'b0);
    chk("rst_uart_rd", uart_rd, 1'b0);
    chk("rst_uart_w", uart_w, 8'h00);
    chk("rst_rx_data", rx_data, 8'h00);
    reset = 1'b0;
    tick(100);
    chk("idle_no_wr", wr_log.size(), 0);
    chk("idle_no_rd", rd_cnt, 0);
    chk("idle_status", status, 8'h01);

    // three back-to-back bytes, UART always ready
    for (int i = 0; i < 3; i++) begin
      tx_push = 1'b1;
      tx_data = 8'h41 + 8'(i);
      tick();
    end
    tx_push = 1'b0;
    tick(20);
    chk("abc_count", wr_log.size(), 3);
    chk("abc_b0", wr_log[0], 8'h41);
    chk("abc_b1", wr_log[1], 8'h42);
    chk("abc_b2", wr_log[2], 8'h43);
    chk("abc_gap01", wr_cyc[1] - wr_cyc[0], 3);
    chk("abc_gap12", wr_cyc[2] - wr_cyc[1], 3);
    chk("abc_status", status, 8'h01);

    // fill TX while busy, then overflow
    wr_log.delete();
    wr_cyc.delete();
    uart_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tx_push = 1'b1;
      tx_data = 8'h10 + 8'(i);
      tick();
    end
    chk("txfull_status", status, 8'h02);
    tx_data = 8'hFF;
    tick();
    chk("txovf_status", status, 8'h12);
    flag_clr = 1'b1;
    tick();
    chk("txovf_clr_loses", status, 8'h12);
    tx_push = 1'b0;
    flag_clr = 1'b0;
    tick(5);
    chk("txbusy_no_wr", wr_log.size(), 0);
    uart_busy = 1'b0;
    tick(60);
    chk("drain_count", wr_log.size(), 16);
    for (int i = 0; i < 16; i++) chk("drain_byte", wr_log[i], 8'h10 + 8'(i));
    chk("drain_status", status, 8'h11);
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    tick();
    chk("txovf_cleared", status, 8'h01);

    // single RX byte
    rd0 = rd_cnt;
    uart_valid = 1'b1;
    uart_data = 8'h5A;
    chk("rx1_rd_before", uart_rd, 1'b0);
    tick();
    chk("rx1_rd_pulse", uart_rd, 1'b1);
    uart_valid = 1'b0;
    tick();
    chk("rx1_rd_done", uart_rd, 1'b0);
    chk("rx1_data", rx_data, 8'h5A);
    chk("rx1_status", status, 8'h05);
    rx_pop = 1'b1;
    tick();
    rx_pop = 1'b0;
    chk("rx1_pop_data", rx_data, 8'h00);
    chk("rx1_pop_status", status, 8'h01);
    rx_pop = 1'b1;
    tick();
    rx_pop = 1'b0;
    chk("rx_pop_empty_status", status, 8'h01);
    chk("rx_pop_empty_data", rx_data, 8'h00);

    // 17 bytes with no pop: 16 accepted, 17th held in the UART
    acks = 0;
    for (int i = 0; i < 16; i++) begin
      rx_byte(8'h80 + 8'(i), 10, acked);
      if (acked) acks++;
    end
    chk("rx16_acks", acks, 16);
    rx_byte(8'hEE, 10, acked);
    chk("rx17_held", acked, 1'b0);
    chk("rx17_rd_low", uart_rd, 1'b0);
    chk("rxfull_status", status, 8'h0D);
    chk("rxfull_head", rx_data, 8'h80);
    rx_pop = 1'b1;
    tick();
    rx_pop = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 2 && !got; i++) begin
      tick();
      got = uart_rd;
    end
    chk("rx17_acked", got, 1'b1);
    uart_valid = 1'b0;
    tick();
    chk("rx17_status", status, 8'h0D);
    chk("rx_rd_total", rd_cnt - rd0, 18);
    for (int i = 0; i < 16; i++) begin
      exp_b = (i < 15) ? 8'h81 + 8'(i) : 8'hEE;
      chk("rx_drain", rx_data, exp_b);
      rx_pop = 1'b1;
      tick();
      rx_pop = 1'b0;
    end
    chk("rx_drain_status", status, 8'h01);

    // reset in the middle of a launch
    wr_log.delete();
    wr_cyc.delete();
    uart_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tx_push = 1'b1;
      tx_data = 8'hA0 + 8'(i);
      tick();
    end
    tx_push = 1'b0;
    uart_busy = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = uart_wr;
    end
    chk("mid_send_reached", got, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_wr", uart_wr, 1'b0);
    chk("mid_rst_status", status, 8'h01);
    tick(2);
    reset = 1'b0;
    wr_log.delete();
    wr_cyc.delete();
    tick(30);
    chk("post_rst_no_wr", wr_log.size(), 0);
    chk("post_rst_status", status, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
